// File: rtl/seq_pkg.sv
// Shared types and helpers for the 7-state display sequencer.
package seq_pkg;

  localparam int NUM_STATES = 7;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6} state_idx_t;

  // Wrap-around step in either direction; dir = 1 walks S6 -> S0.
  function automatic state_idx_t next_idx(input state_idx_t idx, input logic dir);
    state_idx_t n;
    if (!dir) n = (idx == S6) ? S0 : state_idx_t'(idx + 3'd1);
    else      n = (idx == S0) ? S6 : state_idx_t'(idx - 3'd1);
    return n;
  endfunction

  function automatic logic [NUM_STATES-1:0] to_onehot(input state_idx_t idx);
    return NUM_STATES'(1) << idx;
  endfunction

  function automatic logic is_onehot(input logic [NUM_STATES-1:0] v);
    return (v != '0) && ((v & (v - NUM_STATES'(1))) == '0);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low key.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pulse
);

  logic sync0;
  logic sync1;
  logic prev;

  // All stages reset to the released level so a key held through reset
  // produces no edge on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync0 <= btn_n;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign pulse = prev & ~sync1;

endmodule

// File: rtl/state_sequencer.sv
// One-hot state sequencer: timed auto-advance or manual key stepping, either direction.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  step_n,
  output logic [NUM_STATES-1:0] state_out,
  output logic [2:0]            state_idx,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic             step_pulse;
  logic [CNT_W-1:0] cnt;
  logic             terminal;
  logic             adv;

  state_idx_t            idx_q;
  state_idx_t            idx_d;
  logic [NUM_STATES-1:0] oh_d;
  logic                  tick_d;
  logic                  wrap_d;

  btn_edge u_step (
    .clk   (clk),
    .reset (reset),
    .btn_n (step_n),
    .pulse (step_pulse)
  );

  // Prescaler: cleared and held while paused, so a partial count is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (!run)      cnt <= '0;
    else if (terminal)  cnt <= '0;
    else                cnt <= cnt + CNT_W'(1);
  end

  assign terminal = (cnt == TERM);
  assign adv      = (run & terminal) | step_pulse;

  always_comb begin
    idx_d  = idx_q;
    oh_d   = state_out;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (!is_onehot(state_out)) begin
      idx_d = S0;
      oh_d  = to_onehot(S0);
    end else if (adv) begin
      idx_d  = next_idx(idx_q, dir);
      oh_d   = to_onehot(idx_d);
      tick_d = 1'b1;
      wrap_d = dir ? (idx_q == S0) : (idx_q == S6);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= S0;
      state_out <= to_onehot(S0);
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      state_out <= oh_d;
      tick      <= tick_d;
      wrap      <= wrap_d;
    end
  end

  assign state_idx = idx_q;

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Sequencing controller that produces the 7-state one-hot state vector consumed by the state-to-hex display decoder (stateIn_0..stateIn_6 map to state_out[0]..state_out[6]).
- Free-runs through the states on a prescaled timer when enabled, or single-steps on a board push-button when paused, in either direction.
- Sits between board switches/keys and the display decoder; exactly one state bit is high at all times.

Parameters:
- TICK_DIV, 50_000_000, clock cycles per automatic state advance (1 s at 50 MHz); legal range >= 2.
- CNT_W, $clog2(TICK_DIV), prescaler counter width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = auto-advance on prescaler terminal count; 0 = paused, manual stepping only
- dir  input  1  level; 0 = forward (S0->S6), 1 = reverse (S6->S0)
- step_n  input  1  raw active-low push-button (asynchronous to clk); each press advances one state
- state_out  output  7  one-hot current state, bit i = state Si
- state_idx  output  3  binary index of current state, 0..6
- tick  output  1  one-cycle pulse in the cycle an advance is committed (auto or manual)
- wrap  output  1  one-cycle pulse coincident with tick when the advance crosses S6->S0 (forward) or S0->S6 (reverse)

Behaviour:
- Reset (async assert, sync release): state_out = 7'b0000001, state_idx = 0, tick = 0, wrap = 0, prescaler = 0, button synchronizer stages and edge register = 1 (released).
- Button path: two-flop synchronizer on step_n, then an edge register; step_pulse = prev & ~sync1 (falling edge), one cycle wide per press. No debounce; bench drives clean edges.
- Latency: step_n falls before rising edge k -> sync1 low after edge k+1 -> advance committed at edge k+2 (state_out changes at the 3rd rising edge, counting k as the 1st).
- Prescaler: run=1 -> counts 0..TICK_DIV-1, wraps to 0; terminal count (cnt == TICK_DIV-1) raises adv. run=0 -> counter cleared to 0 and held. Falling run while counting discards partial count.
- adv = (run & terminal) | step_pulse. Coincident terminal and step_pulse produce exactly one advance.
- step_pulse while run=1 advances the state immediately but does not reset the prescaler.
- Advance: forward Si -> S(i+1), S6 -> S0; reverse Si -> S(i-1), S0 -> S6. dir is sampled in the advance cycle. A dir change alone causes no state change.
- tick/wrap are registered and go high in the same cycle state_out shows the new state. state_idx is registered and always consistent with state_out.
- Robustness: if state_out is ever not one-hot (e.g. SEU), the next clock forces S0 with state_idx = 0, tick = 0.
- Reset asserted mid-count or mid-press returns to the reset values above. A press still held at reset release does not generate a step, because the edge register releases at 1 and the held button gives no falling edge.

Decomposition:
- Package seq_pkg:
  - NUM_STATES = 7
  - typedef enum logic [2:0] state_idx_t {S0..S6}
  - function next_idx(idx, dir) implementing wrap-around
  - function to_onehot(idx)
- Sub-module btn_edge: 2-FF synchronizer plus falling-edge detector; ports clk, reset, btn_n, pulse. Reused for further keys.
- Top holds the prescaler, the state register (stored as idx, one-hot derived and registered) and the tick/wrap flops.

Test Plan:
- Reset then run=1, dir=0, TICK_DIV=4 -> state_out = 0000001, 0000010, 0000100 ... each 4 cycles apart. tick every 4th cycle. After S6, state_out = 0000001 with wrap=1 exactly once per 28 cycles.
- run=0, dir=1, from S0, one step_n low pulse of 5 cycles -> state_out = 1000000 (S6) at the 3rd edge after the fall, with tick=1 and wrap=1 for one cycle. No further change while held or on release.
- run=1, TICK_DIV=4, step_n falling timed so step_pulse coincides with terminal count at S2 -> single advance to S3 (0001000); next advance 4 cycles later to S4.
- run=1, count at 2 of 4, run->0 for 10 cycles, then run->1 -> state unchanged while paused; next advance exactly 4 cycles after run returns high.
- Assert reset asynchronously (between edges) while at S5 with prescaler mid-count -> state_out = 0000001 and tick = 0 immediately. After release, first advance occurs TICK_DIV cycles later.
- Force state_out to 0000110 via bench force/release -> next edge yields 0000001 and state_idx = 0. Normal sequencing resumes.
